// File: rtl/nn_frame_driver.sv
// nn_frame_driver
//   Host-side driver for the jet-tagging network (dense x4 + softmax).
//   Gathers INPUT_SIZE feature words one per handshake into a registered
//   parallel vector. It launches the network with a one-cycle pulse and waits
//   for the rising edge of the network's result strobe. It then returns the
//   argmax class and its score on a valid/ready port. A watchdog aborts a
//   frame whose result never arrives.
//
// Ports
//   clk              in   clock, all logic on posedge
//   reset            in   asynchronous active-high reset
//   s_valid          in   feature word valid
//   s_ready          out  driver accepts a feature (LOAD only)
//   s_data           in   feature word (signed fixed point, stored as-is)
//   net_input_ready  out  one-cycle launch pulse to the network
//   net_input_data   out  assembled feature vector, entry i at [i*WIDTH +: WIDTH]
//   net_output_ready in   network result strobe (rising edge is the event)
//   net_output_data  in   softmax outputs, entry i at [i*WIDTH +: WIDTH]
//   m_valid          out  result valid
//   m_ready          in   result accepted
//   m_class          out  argmax index
//   m_score          out  winning softmax value
//   timeout_err      out  one-cycle pulse when the watchdog aborts a frame
module nn_frame_driver #(
    parameter int WIDTH       = 4,
    parameter int NFRAC       = 2,
    parameter int INPUT_SIZE  = 16,
    parameter int OUTPUT_SIZE = 5,
    parameter int TIMEOUT     = 1023
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [WIDTH-1:0]               s_data,
    output logic                           net_input_ready,
    output logic [WIDTH*INPUT_SIZE-1:0]    net_input_data,
    input  logic                           net_output_ready,
    input  logic [WIDTH*OUTPUT_SIZE-1:0]   net_output_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [$clog2(OUTPUT_SIZE)-1:0] m_class,
    output logic [WIDTH-1:0]               m_score,
    output logic                           timeout_err
);

    localparam int CLS_W = $clog2(OUTPUT_SIZE);
    localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    // NFRAC only documents the fixed-point format shared with the network.
    if (TIMEOUT < 1 || NFRAC < 0 || NFRAC > WIDTH) begin : g_param_check
        $error("nn_frame_driver: TIMEOUT must be >= 1 and 0 <= NFRAC <= WIDTH");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESULT
    } state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [WD_W-1:0]                 wdog_q, wdog_d;
    logic                            out_rdy_q, out_rdy_d;
    logic [WIDTH*INPUT_SIZE-1:0]     data_q, data_d;
    logic [CLS_W-1:0]                cls_q, cls_d;
    logic [WIDTH-1:0]                score_q, score_d;

    logic                            out_rise;
    logic [CLS_W-1:0]                best_idx;
    logic [WIDTH-1:0]                best_val;

    // Argmax with strict '>' so ties keep the lowest index. Softmax outputs
    // are non-negative, so the comparison is unsigned.
    always_comb begin
        best_idx = '0;
        best_val = net_output_data[WIDTH-1:0];
        for (int i = 1; i < OUTPUT_SIZE; i++) begin
            if (net_output_data[i*WIDTH +: WIDTH] > best_val) begin
                best_val = net_output_data[i*WIDTH +: WIDTH];
                best_idx = CLS_W'(i);
            end
        end
    end

    // A level left high from an earlier frame is never a new result.
    assign out_rise  = net_output_ready && !out_rdy_q;
    assign out_rdy_d = net_output_ready;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        wdog_d          = wdog_q;
        data_d          = data_q;
        cls_d           = cls_q;
        score_d         = score_q;
        s_ready         = 1'b0;
        net_input_ready = 1'b0;
        m_valid         = 1'b0;
        timeout_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    for (int i = 0; i < INPUT_SIZE; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            data_d[i*WIDTH +: WIDTH] = s_data;
                        end
                    end
                    if (idx_q == IDX_W'(INPUT_SIZE - 1)) begin
                        idx_d   = '0;
                        state_d = ST_LAUNCH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            ST_LAUNCH: begin
                net_input_ready = 1'b1;
                wdog_d          = '0;
                state_d         = ST_WAIT;
            end

            ST_WAIT: begin
                // The Nth WAIT cycle sees wdog_q == N-1, so the abort lands
                // on WAIT cycle TIMEOUT. A result edge in that cycle wins.
                wdog_d = wdog_q + 1'b1;
                if (out_rise) begin
                    cls_d   = best_idx;
                    score_d = best_val;
                    state_d = ST_RESULT;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    timeout_err = 1'b1;
                    state_d     = ST_LOAD;
                end
            end

            ST_RESULT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            wdog_q    <= '0;
            out_rdy_q <= 1'b0;
            data_q    <= '0;
            cls_q     <= '0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wdog_q    <= wdog_d;
            out_rdy_q <= out_rdy_d;
            data_q    <= data_d;
            cls_q     <= cls_d;
            score_q   <= score_d;
        end
    end

    assign net_input_data = data_q;
    assign m_class        = cls_q;
    assign m_score        = score_q;

endmodule

// File: tb/tb_nn_frame_driver.sv
module tb_nn_frame_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_data;
    logic        net_input_ready;
    logic [63:0] net_input_data;
    logic        net_output_ready;
    logic [19:0] net_output_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  m_class;
    logic [3:0]  m_score;
    logic        timeout_err;

    int n_total = 0;
    int n_pass  = 0;

    logic [6:0]  sb[$];          // expected {class, score}
    logic        to_expected = 1'b0;
    logic [3:0]  feat[16];

    nn_frame_driver #(
        .WIDTH(4), .NFRAC(2), .INPUT_SIZE(16), .OUTPUT_SIZE(5), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .net_input_ready(net_input_ready),
        .net_input_data(net_input_data),
        .net_output_ready(net_output_ready),
        .net_output_data(net_output_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_class(m_class),
        .m_score(m_score),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [19:0] pk(input logic [3:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    // Feeds feat[0..15]; returns at the sample point of the LAUNCH cycle.
    task automatic load_frame(input int gap);
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = feat[i];
            if (i == 15) chk("launch_early", 32'(net_input_ready), 0);
            step();
            s_valid = 1'b0;
            if (i < 15) repeat (gap) step();
        end
    endtask

    task automatic check_vector(input string tag);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_nid[%0d]", tag, i), 32'(net_input_data[i*4 +: 4]), 32'(feat[i]));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_net_input_ready"}, 32'(net_input_ready), 0);
        chk({tag, "_net_input_data"}, 32'(|net_input_data), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_class"}, 32'(m_class), 0);
        chk({tag, "_m_score"}, 32'(m_score), 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    // Scoreboard monitor: every accepted result is matched against the queue.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(m_valid), 0);
                end else begin
                    logic [6:0] e;
                    e = sb.pop_front();
                    chk("sb_m_class", 32'(m_class), 32'(e[6:4]));
                    chk("sb_m_score", 32'(m_score), 32'(e[3:0]));
                end
            end
            if (timeout_err && !to_expected) chk("unexpected_timeout", 32'(timeout_err), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b0; s_valid = 1'b0; s_data = '0; net_output_ready = 1'b0;
        net_output_data = '0; m_ready = 1'b0;
        #1 reset = 1'b1;
        step(); step();
        check_cleared("rst");
        reset = 1'b0;
        chk("idle_s_ready", 32'(s_ready), 0);
        step();
        chk("load_s_ready", 32'(s_ready), 1);

        // 1: features -8..7 with s_valid toggling
        for (int i = 0; i < 16; i++) feat[i] = 4'(i - 8);
        load_frame(1);
        chk("t1_launch", 32'(net_input_ready), 1);
        chk("t1_launch_s_ready", 32'(s_ready), 0);
        check_vector("t1");
        step();
        chk("t1_launch_end", 32'(net_input_ready), 0);

        // 2: {1,3,9,3,2} -> class 2, score 9; payload held while m_ready low
        net_output_data  = pk(4'd1, 4'd3, 4'd9, 4'd3, 4'd2);
        net_output_ready = 1'b1;
        sb.push_back({3'd2, 4'd9});
        step();
        net_output_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t2_m_valid", 32'(m_valid), 1);
            chk("t2_m_class", 32'(m_class), 2);
            chk("t2_m_score", 32'(m_score), 9);
            chk("t2_s_ready", 32'(s_ready), 0);
            if (k < 4) step();
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("t2_m_valid_drop", 32'(m_valid), 0);
        chk("t2_back_to_load", 32'(s_ready), 1);

        // 3: {4,6,6,1,0} -> tie resolved to lowest index
        for (int i = 0; i < 16; i++) feat[i] = 4'(i);
        load_frame(0);
        chk("t3_launch", 32'(net_input_ready), 1);
        check_vector("t3");
        step();
        net_output_data  = pk(4'd4, 4'd6, 4'd6, 4'd1, 4'd0);
        net_output_ready = 1'b1;
        m_ready          = 1'b1;
        sb.push_back({3'd1, 4'd6});
        step();
        net_output_ready = 1'b0;
        chk("t3_m_valid", 32'(m_valid), 1);
        step();
        m_ready = 1'b0;
        chk("t3_back_to_load", 32'(s_ready), 1);

        // 4: strobe held high since before launch -> watchdog abort
        net_output_ready = 1'b1;
        load_frame(0);
        chk("t4_launch", 32'(net_input_ready), 1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) to_expected = 1'b1;
            step();
            chk($sformatf("t4_timeout_w%0d", k), 32'(timeout_err), (k == 8) ? 1 : 0);
            chk("t4_m_valid", 32'(m_valid), 0);
            chk("t4_s_ready_wait", 32'(s_ready), 0);
        end
        step();
        to_expected      = 1'b0;
        net_output_ready = 1'b0;
        chk("t4_s_ready_after", 32'(s_ready), 1);
        chk("t4_timeout_done", 32'(timeout_err), 0);

        // 5: edge on the 8th WAIT cycle beats the watchdog
        load_frame(0);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 8) begin
                net_output_data  = pk(4'd2, 4'd5, 4'd1, 4'd7, 4'd3);
                net_output_ready = 1'b1;
                m_ready          = 1'b1;
                sb.push_back({3'd3, 4'd7});
                #1;
            end
            chk($sformatf("t5_timeout_w%0d", k), 32'(timeout_err), 0);
        end
        step();
        chk("t5_m_valid", 32'(m_valid), 1);
        chk("t5_m_class", 32'(m_class), 3);
        step();
        m_ready          = 1'b0;
        net_output_ready = 1'b0;
        chk("t5_back_to_load", 32'(s_ready), 1);

        // 6a: reset while waiting
        load_frame(0);
        step(); step();
        reset = 1'b1;
        #1;
        check_cleared("t6a");
        step();
        reset = 1'b0;
        chk("t6a_idle", 32'(s_ready), 0);
        step();
        chk("t6a_load", 32'(s_ready), 1);

        // 6b: reset with 7 features loaded, then a fresh frame
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = 4'(i + 1);
            step();
        end
        s_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_cleared("t6b");
        step();
        reset = 1'b0;
        step();
        chk("t6b_load", 32'(s_ready), 1);
        for (int i = 0; i < 16; i++) feat[i] = 4'(7 - i);
        load_frame(0);
        chk("t6b_launch", 32'(net_input_ready), 1);
        check_vector("t6b");
        step();
        chk("t6b_launch_end", 32'(net_input_ready), 0);
        net_output_data  = pk(4'hF, 4'hF, 4'd0, 4'd0, 4'd0);
        net_output_ready = 1'b1;
        m_ready          = 1'b1;
        sb.push_back({3'd0, 4'hF});
        step();
        net_output_ready = 1'b0;
        step();
        m_ready = 1'b0;
        chk("t6b_back_to_load", 32'(s_ready), 1);

        step();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
